fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/ant_pkg.sv | 11 +
 rtl/fetch_queue.sv | 49 ++++
 rtl/fetch_unit.sv | 69 ++++++
 tb/tb_fetch_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ant_pkg.sv
// Shared fetch-path types and widths.
// Holds the fetch-queue entry layout used by fetch_unit and fetch_queue.
package ant_pkg;
    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instruction;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: power-of-two FIFO of fetch entries with synchronous flush.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: the caller must not push when full (unless popping) or pop when empty.
module fetch_queue
    import ant_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  fetch_entry_t                 push_entry,
    output fetch_entry_t                 head_entry,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   head_ptr;
    logic [PW-1:0]   tail_ptr;

    // Pointers are exactly log2(DEPTH) wide, so increment wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                tail_ptr <= tail_ptr + PW'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset && !flush) begin
            mem[tail_ptr] <= push_entry;
        end
    end

    assign head_entry = mem[head_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, fills the fetch queue and handles redirects.
// Latency: a word fetched in cycle N appears on out_* in cycle N+1.
// Backpressure: fetch stalls (PC holds) while the queue is full and decode is not accepting.
module fetch_unit
    import ant_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instruction
);
    localparam int CW = $clog2(QUEUE_DEPTH+1);

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   count;
    fetch_entry_t    head_entry;
    fetch_entry_t    tail_entry;
    logic            head_vld;
    logic            push;
    logic            pop;
    logic            unused_redirect_lsbs;

    assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

    assign head_vld = (count != '0);
    // Redirect and reset both suppress queue traffic; the head is never consumed.
    assign pop  = head_vld && out_ready && !redirect_valid && !reset;
    assign push = !reset && !redirect_valid && ((count < CW'(QUEUE_DEPTH)) || pop);

    assign tail_entry.pc          = pc;
    assign tail_entry.instruction = imem_instruction;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            pc <= pc + XLEN'(INSTR_BYTES);
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fetch_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push),
        .pop        (pop),
        .push_entry (tail_entry),
        .head_entry (head_entry),
        .count      (count)
    );

    assign imem_pc         = pc;
    assign out_valid       = head_vld;
    assign out_pc          = head_vld ? head_entry.pc          : '0;
    assign out_instruction = head_vld ? head_entry.instruction : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk;
    logic        reset;
    logic [31:0] imem_pc;
    logic [31:0] imem_instruction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] model_q[$];
    logic [31:0] model_pc;

    fetch_unit #(
        .RESET_PC    (RESET_PC),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_pc          (imem_pc),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_pc           (out_pc),
        .out_instruction  (out_instruction)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h1000_0000 + {2'b00, addr[31:2]};
    endfunction

    assign imem_instruction = mem_word(imem_pc);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Called at a negedge: drive inputs, advance the model, then compare at the next negedge.
    task automatic tick(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic        do_pop;
        logic        do_push;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic        exp_vld;
        reset          = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        if (r) begin
            model_q.delete();
            model_pc = RESET_PC;
        end else if (rv) begin
            model_q.delete();
            model_pc = rpc & 32'hFFFF_FFFC;
        end else begin
            do_pop  = (model_q.size() > 0) && rdy;
            do_push = (model_q.size() < DEPTH) || do_pop;
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                model_q.push_back(model_pc);
                model_pc = model_pc + 32'd4;
            end
        end
        @(negedge clk);
        exp_vld   = (model_q.size() > 0);
        exp_pc    = exp_vld ? model_q[0] : 32'h0;
        exp_instr = exp_vld ? mem_word(model_q[0]) : 32'h0;
        check_eq("model_imem_pc", imem_pc, model_pc);
        check_eq("model_out_valid", {31'b0, out_valid}, {31'b0, exp_vld});
        check_eq("model_out_pc", out_pc, exp_pc);
        check_eq("model_out_instr", out_instruction, exp_instr);
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        model_pc       = RESET_PC;
        @(negedge clk);

        // Reset values, then streaming fetch with decode always ready
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_out_pc", out_pc, 32'h0);
        check_eq("rst_out_instr", out_instruction, 32'h0);
        check_eq("rst_imem_pc", imem_pc, RESET_PC);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("first_valid", {31'b0, out_valid}, 32'd1);
        check_eq("first_pc", out_pc, 32'h0);
        check_eq("first_instr", out_instruction, 32'h1000_0000);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("stream1_pc", out_pc, 32'h4);
        check_eq("stream1_instr", out_instruction, 32'h1000_0001);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("stream2_pc", out_pc, 32'h8);
        check_eq("stream2_instr", out_instruction, 32'h1000_0002);

        // Stall from reset: queue fills, PC holds, head stays put
        tick(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("stall_imem_pc", imem_pc, 32'h8);
        check_eq("stall_out_pc", out_pc, 32'h0);
        check_eq("stall_out_valid", {31'b0, out_valid}, 32'd1);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("drain1_pc", out_pc, 32'h4);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("drain2_pc", out_pc, 32'h8);

        // Redirect with a full queue and decode ready
        tick(1'b0, 1'b1, 32'h0000_0103, 1'b1);
        check_eq("redir_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("redir_imem_pc", imem_pc, 32'h100);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("redir_out_pc", out_pc, 32'h100);

        // PC wraps past the top of the address space
        tick(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("wrap0_pc", out_pc, 32'hFFFF_FFF8);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("wrap1_pc", out_pc, 32'hFFFF_FFFC);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("wrap2_pc", out_pc, 32'h0);

        // Mid-operation reset discards queued entries
        tick(1'b1, 1'b0, 32'h0, 1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("midrst_restart_pc", out_pc, RESET_PC);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("midrst_next_pc", out_pc, RESET_PC + 32'h4);

        // Reset dominates a concurrent redirect
        tick(1'b1, 1'b1, 32'h0000_0200, 1'b1);
        check_eq("rst_over_redir_pc", imem_pc, RESET_PC);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(63) == 0), ($urandom_range(9) == 0), $urandom,
                 ($urandom_range(9) < 7));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
